// File: rtl/di_term_pkg.sv
// Shared constants for the di FIFO terminal: register map, status codes and FSM encodings.
package di_term_pkg;

  localparam logic [31:0] ADDR_DATA   = 32'd0;
  localparam logic [31:0] ADDR_STATUS = 32'd1;
  localparam logic [31:0] ADDR_CTRL   = 32'd2;

  localparam logic [15:0] ST_OK         = 16'h0000;
  localparam logic [15:0] ST_WR_TIMEOUT = 16'h0001;
  localparam logic [15:0] ST_RD_TIMEOUT = 16'h0002;
  localparam logic [15:0] ST_BAD_ADDR   = 16'h0003;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_RDY  = 2'd2;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_WAIT = 1'b1;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/di_sync_fifo.sv
// 32-bit synchronous FIFO with occupancy count and a flush that discards same-cycle push/pop.
module di_sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [31:0]         push_data,
  input  logic                pop,
  output logic [31:0]         head,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    do_pop  = pop & ~empty & ~flush & ~reset;
    do_push = push & (~full | do_pop) & ~flush & ~reset;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= {DEPTH_LOG2{1'b0}};
      rd_ptr <= {DEPTH_LOG2{1'b0}};
      count  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
      case ({do_push, do_pop})
        2'b10:   count <= count + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   count <= count - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == {(DEPTH_LOG2 + 1){1'b0}});

endmodule

// File: rtl/di_fifo_terminal.sv
// di-bus terminal bridging host single-word reads/writes onto an h2f and an f2h FIFO,
// with bounded waits so the host bridge always gets a completion.
module di_fifo_terminal
  import di_term_pkg::*;
#(
  parameter logic [15:0] TERM_ADDR  = 16'h0010,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          TIMEOUT    = 1024
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic [15:0] di_term_addr,
  input  logic [31:0] di_reg_addr,
  input  logic [31:0] di_len,
  input  logic        di_read_mode,
  input  logic        di_read_req,
  input  logic        di_read,
  output logic        di_read_rdy,
  output logic [31:0] di_reg_datao,
  input  logic        di_write_mode,
  input  logic        di_write,
  output logic        di_write_rdy,
  input  logic [31:0] di_reg_datai,
  output logic [15:0] di_transfer_status,
  output logic [31:0] h2f_data,
  output logic        h2f_valid,
  input  logic        h2f_ready,
  input  logic [31:0] f2h_data,
  input  logic        f2h_valid,
  output logic        f2h_ready
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_ONE  = CW'(1);

  logic                sel;
  logic [1:0]          rd_state;
  logic [0:0]          wr_state;
  logic [31:0]         addr;
  logic [CW-1:0]       tmo_cnt;
  logic                tmo_hit;
  logic [31:0]         rd_data;
  logic                write_mode_q;
  logic                wr_accept;
  logic                rd_accept;
  logic                flush;
  logic                h2f_push;
  logic                f2h_pop;
  logic                h2f_full;
  logic                h2f_empty;
  logic                f2h_full;
  logic                f2h_empty;
  logic [31:0]         f2h_head;
  logic [DEPTH_LOG2:0] h2f_count;
  logic [DEPTH_LOG2:0] f2h_count;
  logic                unused_inputs;

  assign unused_inputs = ^{di_len, di_read_mode};

  always_comb begin
    sel       = (di_term_addr == TERM_ADDR);
    tmo_hit   = (tmo_cnt == TMO_LAST);
    wr_accept = sel & di_write & (wr_state == WR_WAIT);
    rd_accept = sel & di_read & (rd_state == RD_RDY);
    flush     = wr_accept & (addr == ADDR_CTRL) & di_reg_datai[0];
    h2f_push  = wr_accept & (addr == ADDR_DATA) & ~h2f_full;
    f2h_pop   = rd_accept & (addr == ADDR_DATA) & (di_transfer_status != ST_RD_TIMEOUT);
    if (sel && (wr_state == WR_WAIT)) begin
      di_write_rdy = (addr == ADDR_DATA) ? (~h2f_full | tmo_hit) : 1'b1;
    end else begin
      di_write_rdy = 1'b0;
    end
    di_read_rdy  = sel & (rd_state == RD_RDY);
    di_reg_datao = sel ? rd_data : 32'd0;
    h2f_valid    = ~h2f_empty;
    f2h_ready    = ~f2h_full;
  end

  // Read and write FSMs share the address latch, status and timeout counter;
  // upstream never overlaps a read with a write.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      rd_state           <= RD_IDLE;
      wr_state           <= WR_IDLE;
      addr               <= 32'd0;
      tmo_cnt            <= {CW{1'b0}};
      rd_data            <= 32'd0;
      write_mode_q       <= 1'b0;
      di_transfer_status <= ST_OK;
    end else begin
      write_mode_q <= di_write_mode;
      case (rd_state)
        RD_IDLE: begin
          if (di_read_req && sel) begin
            addr               <= di_reg_addr;
            di_transfer_status <= ST_OK;
            tmo_cnt            <= {CW{1'b0}};
            rd_state           <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          case (addr)
            ADDR_DATA: begin
              if (!f2h_empty) begin
                rd_data  <= f2h_head;
                rd_state <= RD_RDY;
              end else if (tmo_hit) begin
                rd_data            <= 32'd0;
                di_transfer_status <= ST_RD_TIMEOUT;
                rd_state           <= RD_RDY;
              end else begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
              end
            end
            ADDR_STATUS: begin
              rd_data  <= {16'(f2h_count), 16'(h2f_count)};
              rd_state <= RD_RDY;
            end
            ADDR_CTRL: begin
              rd_data  <= 32'd0;
              rd_state <= RD_RDY;
            end
            default: begin
              rd_data            <= BAD_ADDR_DATA;
              di_transfer_status <= ST_BAD_ADDR;
              rd_state           <= RD_RDY;
            end
          endcase
        end
        RD_RDY: begin
          if (rd_accept) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
      case (wr_state)
        WR_IDLE: begin
          if (di_write_mode && !write_mode_q && sel) begin
            addr               <= di_reg_addr;
            di_transfer_status <= ST_OK;
            tmo_cnt            <= {CW{1'b0}};
            wr_state           <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wr_accept) begin
            case (addr)
              ADDR_DATA:   if (h2f_full) di_transfer_status <= ST_WR_TIMEOUT;
              ADDR_STATUS: ;
              ADDR_CTRL:   ;
              default:     di_transfer_status <= ST_BAD_ADDR;
            endcase
            wr_state <= WR_IDLE;
          end else if ((addr == ADDR_DATA) && h2f_full && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  di_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_h2f (
    .clk(ifclk), .reset(reset), .flush(flush),
    .push(h2f_push), .push_data(di_reg_datai), .pop(h2f_ready),
    .head(h2f_data), .count(h2f_count), .full(h2f_full), .empty(h2f_empty)
  );

  di_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_f2h (
    .clk(ifclk), .reset(reset), .flush(flush),
    .push(f2h_valid), .push_data(f2h_data), .pop(f2h_pop),
    .head(f2h_head), .count(f2h_count), .full(f2h_full), .empty(f2h_empty)
  );

endmodule

// File: tb/tb_di_fifo_terminal.sv
// Directed bench for di_fifo_terminal: host read/write tasks plus fabric-side drives.
module tb_di_fifo_terminal;

  localparam logic [15:0] TERM  = 16'h0010;
  localparam int          LIMIT = 2000;

  logic        ifclk = 1'b0;
  logic        reset;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic [31:0] di_len;
  logic        di_read_mode, di_read_req, di_read, di_read_rdy;
  logic [31:0] di_reg_datao;
  logic        di_write_mode, di_write, di_write_rdy;
  logic [31:0] di_reg_datai;
  logic [15:0] di_transfer_status;
  logic [31:0] h2f_data;
  logic        h2f_valid, h2f_ready;
  logic [31:0] f2h_data;
  logic        f2h_valid, f2h_ready;

  int checks = 0;
  int passed = 0;

  di_fifo_terminal dut (
    .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_len(di_len), .di_read_mode(di_read_mode), .di_read_req(di_read_req),
    .di_read(di_read), .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
    .di_write_mode(di_write_mode), .di_write(di_write), .di_write_rdy(di_write_rdy),
    .di_reg_datai(di_reg_datai), .di_transfer_status(di_transfer_status),
    .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
    .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready)
  );

  always #5 ifclk = ~ifclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge ifclk);
    #1;
  endtask

  task automatic host_read(input logic [31:0] a, input bit push_en, input logic [31:0] pd,
                           output logic [31:0] d, output int cyc);
    step();
    di_reg_addr = a; di_read_mode = 1'b1; di_read_req = 1'b1;
    step();
    di_read_req = 1'b0;
    cyc = 1;
    while (!di_read_rdy && cyc < LIMIT) begin
      step();
      cyc++;
    end
    d = di_reg_datao;
    di_read = 1'b1;
    if (push_en) begin
      f2h_valid = 1'b1; f2h_data = pd;
    end
    step();
    di_read = 1'b0; di_read_mode = 1'b0; f2h_valid = 1'b0;
    chk("rd_rdy_drop", {31'd0, di_read_rdy}, 32'd0);
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] wd, input int pulse,
                            output int cyc);
    step();
    di_reg_addr = a; di_reg_datai = wd; di_write_mode = 1'b1;
    step();
    cyc = 0;
    while (!di_write_rdy && cyc < LIMIT) begin
      h2f_ready = (cyc == pulse);
      step();
      cyc++;
    end
    h2f_ready = 1'b0;
    di_write = 1'b1;
    step();
    di_write = 1'b0; di_write_mode = 1'b0;
  endtask

  task automatic f2h_push(input logic [31:0] v);
    f2h_valid = 1'b1; f2h_data = v;
    step();
    f2h_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          cyc;
    reset = 1'b1; di_term_addr = TERM; di_reg_addr = 32'd0; di_len = 32'd1;
    di_read_mode = 1'b0; di_read_req = 1'b0; di_read = 1'b0;
    di_write_mode = 1'b0; di_write = 1'b0; di_reg_datai = 32'd0;
    h2f_ready = 1'b0; f2h_data = 32'd0; f2h_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_read_rdy", {31'd0, di_read_rdy}, 32'd0);
    chk("rst_write_rdy", {31'd0, di_write_rdy}, 32'd0);
    chk("rst_datao", di_reg_datao, 32'd0);
    chk("rst_status", {16'd0, di_transfer_status}, 32'd0);
    chk("rst_h2f_valid", {31'd0, h2f_valid}, 32'd0);
    chk("rst_f2h_ready", {31'd0, f2h_ready}, 32'd1);

    // Single h2f word through to the fabric.
    host_write(32'd0, 32'h1234_5678, -1, cyc);
    chk("w1_cycles", cyc, 32'd0);
    chk("w1_status", {16'd0, di_transfer_status}, 32'd0);
    chk("w1_h2f_valid", {31'd0, h2f_valid}, 32'd1);
    chk("w1_h2f_data", h2f_data, 32'h1234_5678);
    h2f_ready = 1'b1;
    step();
    h2f_ready = 1'b0;
    chk("w1_h2f_empty", {31'd0, h2f_valid}, 32'd0);

    // Three f2h words read back in order with minimum latency.
    f2h_push(32'hA); f2h_push(32'hB); f2h_push(32'hC);
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("lvl_3_0", d, 32'h0003_0000);
    host_read(32'd0, 1'b0, 32'd0, d, cyc);
    chk("rdA", d, 32'hA);
    chk("rdA_lat", cyc, 32'd2);
    host_read(32'd0, 1'b0, 32'd0, d, cyc);
    chk("rdB", d, 32'hB);
    host_read(32'd0, 1'b0, 32'd0, d, cyc);
    chk("rdC", d, 32'hC);
    chk("rdC_lat", cyc, 32'd2);
    chk("rdC_status", {16'd0, di_transfer_status}, 32'd0);
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("lvl_empty", d, 32'h0000_0000);

    // Full h2f: timed-out write is dropped, then a fabric pop lets a write through.
    for (int i = 0; i < 16; i++) host_write(32'd0, 32'h100 + i, -1, cyc);
    host_write(32'd0, 32'hBAD, -1, cyc);
    chk("wto_cycles", cyc, 32'd1023);
    chk("wto_status", {16'd0, di_transfer_status}, 32'd1);
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("wto_lvl", d, 32'h0000_0010);
    host_write(32'd0, 32'h1717, 5, cyc);
    chk("wpulse_cycles", cyc, 32'd6);
    chk("wpulse_status", {16'd0, di_transfer_status}, 32'd0);
    h2f_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("h2f_drain", h2f_data, (i < 15) ? 32'h101 + i : 32'h1717);
      step();
    end
    h2f_ready = 1'b0;
    chk("h2f_drained", {31'd0, h2f_valid}, 32'd0);

    // Empty f2h read times out without disturbing the FIFO.
    host_read(32'd0, 1'b0, 32'd0, d, cyc);
    chk("rto_cycles", cyc, 32'd1025);
    chk("rto_data", d, 32'd0);
    chk("rto_status", {16'd0, di_transfer_status}, 32'd2);
    f2h_push(32'hD1);
    host_read(32'd0, 1'b0, 32'd0, d, cyc);
    chk("rto_next", d, 32'hD1);

    // Full f2h with push and pop in the same cycle, across pointer wrap.
    for (int i = 0; i < 16; i++) f2h_push(32'h200 + i);
    chk("f2h_full", {31'd0, f2h_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      host_read(32'd0, 1'b1, 32'h300 + k, d, cyc);
      chk("simul_rd", d, 32'h200 + k);
    end
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("simul_lvl", d, 32'h0010_0000);
    for (int i = 0; i < 16; i++) begin
      host_read(32'd0, 1'b0, 32'd0, d, cyc);
      chk("wrap_drain", d, (i < 12) ? 32'h204 + i : 32'h300 + i - 12);
    end

    // Flush with both FIFOs half full.
    for (int i = 0; i < 8; i++) host_write(32'd0, 32'h400 + i, -1, cyc);
    for (int i = 0; i < 8; i++) f2h_push(32'h500 + i);
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("half_lvl", d, 32'h0008_0008);
    host_write(32'd2, 32'd1, -1, cyc);
    chk("flush_h2f", {31'd0, h2f_valid}, 32'd0);
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("flush_lvl", d, 32'd0);
    host_read(32'd2, 1'b0, 32'd0, d, cyc);
    chk("ctrl_rd", d, 32'd0);

    // Unmapped register addresses.
    host_read(32'd5, 1'b0, 32'd0, d, cyc);
    chk("bad_rd_data", d, 32'hDEAD_BEEF);
    chk("bad_rd_status", {16'd0, di_transfer_status}, 32'd3);
    host_write(32'd7, 32'd9, -1, cyc);
    chk("bad_wr_status", {16'd0, di_transfer_status}, 32'd3);

    // Reset while a read is waiting on an empty f2h.
    di_reg_addr = 32'd0; di_read_mode = 1'b1; di_read_req = 1'b1;
    step();
    di_read_req = 1'b0;
    repeat (3) step();
    chk("pre_rst_rdy", {31'd0, di_read_rdy}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0; di_read_mode = 1'b0;
    chk("mid_rst_rdy", {31'd0, di_read_rdy}, 32'd0);
    chk("mid_rst_status", {16'd0, di_transfer_status}, 32'd0);
    host_read(32'd1, 1'b0, 32'd0, d, cyc);
    chk("post_rst_lat", cyc, 32'd2);

    // Other terminal addresses are ignored.
    di_term_addr = 16'h0011; di_reg_addr = 32'd1; di_read_mode = 1'b1; di_read_req = 1'b1;
    step();
    di_read_req = 1'b0;
    repeat (4) step();
    chk("nosel_read_rdy", {31'd0, di_read_rdy}, 32'd0);
    chk("nosel_datao", di_reg_datao, 32'd0);
    di_read_mode = 1'b0; di_write_mode = 1'b1;
    repeat (3) step();
    chk("nosel_write_rdy", {31'd0, di_write_rdy}, 32'd0);
    di_write_mode = 1'b0; di_term_addr = TERM;
    step();
    chk("nosel_idle_rdy", {31'd0, di_write_rdy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
